// File: rtl/regfile_pkg.sv
// regfile_pkg: write-op and sweep-FSM encodings shared by
// the register bank, its bus interface and its ALU.
package regfile_pkg;

    typedef logic [1:0] wrOp_t;

    localparam wrOp_t OP_LOAD = 2'b00;
    localparam wrOp_t OP_ADD  = 2'b01;
    localparam wrOp_t OP_INC  = 2'b10;
    localparam wrOp_t OP_CLR  = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: write/read/sweep bus of the register bank.
// master drives requests and addresses; slave returns data and status.
interface regfile_multiport_if import regfile_pkg::*; #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8
);
    localparam int AW = clog2(NUM_REGS);

    logic                      wr_en;
    logic                      wr_ready;
    logic [AW-1:0]             wr_addr;
    wrOp_t                     wr_op;
    logic [WIDTH-1:0]          wr_data;
    logic [AW-1:0]             rd_addr_a;
    logic [WIDTH-1:0]          rd_data_a;
    logic [AW-1:0]             rd_addr_b;
    logic [WIDTH-1:0]          rd_data_b;
    logic                      clr_start;
    logic                      busy;
    logic                      ovf;
    logic                      addr_err;
    logic [NUM_REGS*WIDTH-1:0] regs_flat;

    modport master (
        output wr_en, wr_addr, wr_op, wr_data,
        output rd_addr_a, rd_addr_b, clr_start,
        input  wr_ready, rd_data_a, rd_data_b,
        input  busy, ovf, addr_err, regs_flat
    );

    modport slave (
        input  wr_en, wr_addr, wr_op, wr_data,
        input  rd_addr_a, rd_addr_b, clr_start,
        output wr_ready, rd_data_a, rd_data_b,
        output busy, ovf, addr_err, regs_flat
    );

endinterface

// File: rtl/regfile_alu.sv
// regfile_alu: next value and carry for one write (LOAD/ADD/INC/CLR).
// Ports: cur, addend, op in; nextVal, carry (ADD/INC only) out.
module regfile_alu import regfile_pkg::*; #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] addend,
    input  wrOp_t            op,
    output logic [WIDTH-1:0] nextVal,
    output logic             carry
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum     = '0;
        carry   = 1'b0;
        nextVal = cur;
        unique case (1'b1)
            (op == OP_LOAD): nextVal = addend;
            (op == OP_ADD), (op == OP_INC): begin
                if (op == OP_INC) sum = {1'b0, cur} + (WIDTH+1)'(1);
                else              sum = {1'b0, cur} + {1'b0, addend};
                carry = sum[WIDTH];
                if (carry && (SATURATE != 0)) nextVal = '1;
                else                          nextVal = sum[WIDTH-1:0];
            end
            (op == OP_CLR): nextVal = '0;
            default:        nextVal = cur;
        endcase
    end

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register bank, two async read ports,
// ALU writes and a sweep-clear FSM. Ports: clk, rst, bus (slave).
module regfile_multiport import regfile_pkg::*; #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SATURATE = 0,
    parameter int BYPASS   = 1
) (
    input logic                clk,
    input logic                rst,
    regfile_multiport_if.slave bus
);

    localparam int            AW    = clog2(NUM_REGS);
    localparam logic [AW:0]   NUM_W = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST  = AW'(NUM_REGS - 1);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [1:0]       state;
    logic [AW-1:0]    idx;
    logic             ovfQ;
    logic             addrErrQ;

    logic             wrAccept;
    logic             addrOk;
    logic             wrValid;
    logic             carry;
    logic [WIDTH-1:0] curVal;
    logic [WIDTH-1:0] nextVal;
    logic [WIDTH-1:0] rdA;
    logic [WIDTH-1:0] rdB;

    assign bus.wr_ready = (state == IDLE) & ~bus.clr_start;
    assign bus.busy     = (state != IDLE);
    assign bus.ovf      = ovfQ;
    assign bus.addr_err = addrErrQ;

    assign wrAccept = bus.wr_en & bus.wr_ready;
    assign addrOk   = ({1'b0, bus.wr_addr} < NUM_W);
    assign wrValid  = wrAccept & addrOk;

    // Loop muxes: addresses past NUM_REGS match nothing and read 0.
    always_comb begin
        curVal = '0;
        rdA    = '0;
        rdB    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.wr_addr   == AW'(i)) curVal = regs[i];
            if (bus.rd_addr_a == AW'(i)) rdA    = regs[i];
            if (bus.rd_addr_b == AW'(i)) rdB    = regs[i];
        end
    end

    always_comb begin
        bus.regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.regs_flat[i*WIDTH +: WIDTH] = regs[i];
        end
    end

    regfile_alu #(
        .WIDTH   (WIDTH),
        .SATURATE(SATURATE)
    ) uAlu (
        .cur    (curVal),
        .addend (bus.wr_data),
        .op     (bus.wr_op),
        .nextVal(nextVal),
        .carry  (carry)
    );

    // Forward the same ALU result that is about to be stored.
    assign bus.rd_data_a =
        ((BYPASS != 0) && wrValid && (bus.rd_addr_a == bus.wr_addr))
        ? nextVal : rdA;
    assign bus.rd_data_b =
        ((BYPASS != 0) && wrValid && (bus.rd_addr_b == bus.wr_addr))
        ? nextVal : rdB;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            state    <= IDLE;
            idx      <= '0;
            ovfQ     <= 1'b0;
            addrErrQ <= 1'b0;
        end else begin
            ovfQ     <= wrValid & carry;
            addrErrQ <= wrAccept & ~addrOk;
            // Writes only land in IDLE and sweeps only in CLEAR.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrValid && (bus.wr_addr == AW'(i)))
                    regs[i] <= nextVal;
                if ((state == CLEAR) && (idx == AW'(i)))
                    regs[i] <= '0;
            end
            unique case (1'b1)
                (state == IDLE): begin
                    if (bus.clr_start) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                (state == CLEAR): begin
                    if (idx == LAST) state <= DONE;
                    else             idx   <= idx + AW'(1);
                end
                (state == DONE): state <= IDLE;
                default:         state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vectors on two configurations,
// 8 regs/wrap/bypass (d0) and 6 regs/saturate/no-bypass (d1).
module tb_regfile_multiport;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrEn = 1'b0;
    logic [1:0] wrOp = OP_LOAD;
    logic [2:0] wrAddr = '0;
    logic [7:0] wrData = '0;
    logic [2:0] rdA = '0;
    logic [2:0] rdB = '0;
    logic       clrStart = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.WIDTH(8), .NUM_REGS(8)) i0 ();
    regfile_multiport_if #(.WIDTH(8), .NUM_REGS(6)) i1 ();

    assign i0.wr_en = wrEn;     assign i1.wr_en = wrEn;
    assign i0.wr_op = wrOp;     assign i1.wr_op = wrOp;
    assign i0.wr_addr = wrAddr; assign i1.wr_addr = wrAddr;
    assign i0.wr_data = wrData; assign i1.wr_data = wrData;
    assign i0.rd_addr_a = rdA;  assign i1.rd_addr_a = rdA;
    assign i0.rd_addr_b = rdB;  assign i1.rd_addr_b = rdB;
    assign i0.clr_start = clrStart;
    assign i1.clr_start = clrStart;

    regfile_multiport #(
        .WIDTH(8), .NUM_REGS(8), .SATURATE(0), .BYPASS(1)
    ) d0 (.clk(clk), .rst(rst), .bus(i0));

    regfile_multiport #(
        .WIDTH(8), .NUM_REGS(6), .SATURATE(1), .BYPASS(0)
    ) d1 (.clk(clk), .rst(rst), .bus(i1));

    typedef struct {
        logic       we;
        logic [1:0] op;
        logic [2:0] addr;
        logic [7:0] data;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] expA0;
        logic [7:0] expA1;
        logic [7:0] expB0;
        logic       ovf0;
        logic       ovf1;
        logic       err1;
    } vec_t;

    vec_t vt [17];
    logic [7:0] old0 [8];
    logic [7:0] old1 [6];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [1:0] op,
        input logic [2:0] addr, input logic [7:0] data,
        input logic [2:0] ra, input logic [2:0] rb,
        input logic [7:0] a0, input logic [7:0] a1,
        input logic [7:0] b0, input logic o0,
        input logic o1, input logic e1);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.data = data;
        v.ra = ra; v.rb = rb; v.expA0 = a0; v.expA1 = a1;
        v.expB0 = b0; v.ovf0 = o0; v.ovf1 = o1; v.err1 = e1;
        return v;
    endfunction

    task automatic write1(input logic [1:0] op,
                          input logic [2:0] addr,
                          input logic [7:0] data);
        @(negedge clk);
        wrEn = 1'b1; wrOp = op; wrAddr = addr; wrData = data;
        @(posedge clk); #1;
        wrEn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cnt0;
        int cnt1;

        vt[0]  = mk(1, OP_LOAD, 1, 8'h01, 1, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0);
        vt[1]  = mk(1, OP_LOAD, 2, 8'h02, 2, 1, 8'h02, 8'h00, 8'h01, 0, 0, 0);
        vt[2]  = mk(1, OP_LOAD, 3, 8'h03, 3, 3, 8'h03, 8'h00, 8'h03, 0, 0, 0);
        vt[3]  = mk(1, OP_LOAD, 4, 8'h04, 4, 2, 8'h04, 8'h00, 8'h02, 0, 0, 0);
        vt[4]  = mk(1, OP_LOAD, 5, 8'h05, 5, 4, 8'h05, 8'h00, 8'h04, 0, 0, 0);
        vt[5]  = mk(1, OP_LOAD, 6, 8'h06, 6, 6, 8'h06, 8'h00, 8'h06, 0, 0, 1);
        vt[6]  = mk(1, OP_LOAD, 3, 8'hFE, 3, 3, 8'hFE, 8'h03, 8'hFE, 0, 0, 0);
        vt[7]  = mk(1, OP_INC,  3, 8'h00, 3, 5, 8'hFF, 8'hFE, 8'h05, 0, 0, 0);
        vt[8]  = mk(1, OP_INC,  3, 8'h00, 3, 3, 8'h00, 8'hFF, 8'h00, 1, 1, 0);
        vt[9]  = mk(0, OP_LOAD, 0, 8'h00, 3, 6, 8'h00, 8'hFF, 8'h06, 0, 0, 0);
        vt[10] = mk(1, OP_ADD,  1, 8'h10, 1, 1, 8'h11, 8'h01, 8'h11, 0, 0, 0);
        vt[11] = mk(1, OP_ADD,  1, 8'hF0, 1, 2, 8'h01, 8'h11, 8'h02, 1, 1, 0);
        vt[12] = mk(1, OP_CLR,  1, 8'h00, 1, 1, 8'h00, 8'hFF, 8'h00, 0, 0, 0);
        vt[13] = mk(1, OP_LOAD, 2, 8'h55, 2, 1, 8'h55, 8'h02, 8'h00, 0, 0, 0);
        vt[14] = mk(0, OP_LOAD, 0, 8'h00, 2, 2, 8'h55, 8'h55, 8'h55, 0, 0, 0);
        vt[15] = mk(1, OP_LOAD, 7, 8'hAA, 7, 4, 8'hAA, 8'h00, 8'h04, 0, 0, 1);
        vt[16] = mk(0, OP_LOAD, 0, 8'h00, 7, 7, 8'hAA, 8'h00, 8'hAA, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_flat0", i0.regs_flat, 64'h0);
        chk("rst_flat1", i1.regs_flat, 64'h0);
        chk("rst_busy0", i0.busy, 0);
        chk("rst_ready0", i0.wr_ready, 1);
        chk("rst_ready1", i1.wr_ready, 1);
        chk("rst_ovf0", i0.ovf, 0);
        chk("rst_err1", i1.addr_err, 0);

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            wrEn = vt[k].we; wrOp = vt[k].op;
            wrAddr = vt[k].addr; wrData = vt[k].data;
            rdA = vt[k].ra; rdB = vt[k].rb;
            #2;
            chk($sformatf("v%0d_rdA0", k), i0.rd_data_a, vt[k].expA0);
            chk($sformatf("v%0d_rdA1", k), i1.rd_data_a, vt[k].expA1);
            chk($sformatf("v%0d_rdB0", k), i0.rd_data_b, vt[k].expB0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ovf0", k), i0.ovf, vt[k].ovf0);
            chk($sformatf("v%0d_ovf1", k), i1.ovf, vt[k].ovf1);
            chk($sformatf("v%0d_err1", k), i1.addr_err, vt[k].err1);
            chk($sformatf("v%0d_err0", k), i0.addr_err, 0);
        end
        wrEn = 1'b0;
        chk("tbl_flat0", i0.regs_flat, 64'hAA06_0504_0055_0000);
        chk("tbl_flat1", i1.regs_flat, 64'h0504_FF55_0000);

        write1(OP_LOAD, 0, 8'h10);
        write1(OP_LOAD, 1, 8'h11);
        write1(OP_LOAD, 3, 8'h13);
        old0 = '{8'h10, 8'h11, 8'h55, 8'h13,
                 8'h04, 8'h05, 8'h06, 8'hAA};
        old1 = '{8'h10, 8'h11, 8'h55, 8'h13, 8'h04, 8'h05};

        @(negedge clk);
        clrStart = 1'b1;
        rdA = 3'd5;
        #2;
        chk("sw_ready0", i0.wr_ready, 0);
        chk("sw_ready1", i1.wr_ready, 0);
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (i0.busy) cnt0++;
            if (i1.busy) cnt1++;
            if (c >= 1 && c <= 8)
                chk($sformatf("sw%0d_clr0", c),
                    i0.regs_flat[(c-1)*8 +: 8], 0);
            if (c <= 7)
                chk($sformatf("sw%0d_keep0", c),
                    i0.regs_flat[c*8 +: 8], old0[c]);
            if (c >= 1 && c <= 6)
                chk($sformatf("sw%0d_clr1", c),
                    i1.regs_flat[(c-1)*8 +: 8], 0);
            if (c <= 5)
                chk($sformatf("sw%0d_keep1", c),
                    i1.regs_flat[c*8 +: 8], old1[c]);
            if (c == 2) begin
                chk("sw_wr_drop0", i0.regs_flat[5*8 +: 8], 8'h05);
                chk("sw_wr_drop1", i1.regs_flat[5*8 +: 8], 8'h05);
            end
            @(negedge clk);
            clrStart = (c == 2);
            wrEn = (c == 0);
            wrOp = OP_LOAD; wrAddr = 3'd5; wrData = 8'h77;
            #2;
            chk($sformatf("sw%0d_rdA0", c), i0.rd_data_a,
                (c >= 6) ? 8'h00 : 8'h05);
        end
        chk("sw_busy_len0", cnt0, 9);
        chk("sw_busy_len1", cnt1, 7);
        chk("sw_flat0", i0.regs_flat, 64'h0);
        chk("sw_flat1", i1.regs_flat, 64'h0);
        chk("sw_ready_end0", i0.wr_ready, 1);

        for (int k = 0; k < 8; k++)
            write1(OP_LOAD, 3'(k), 8'h20 + 8'(k));
        @(negedge clk);
        clrStart = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        clrStart = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ab_pre_r3", i0.regs_flat[3*8 +: 8], 8'h23);
        chk("ab_pre_busy", i0.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ab_flat0", i0.regs_flat, 64'h0);
        chk("ab_flat1", i1.regs_flat, 64'h0);
        chk("ab_busy0", i0.busy, 0);
        chk("ab_busy1", i1.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("ab_ready0", i0.wr_ready, 1);
        chk("ab_ready1", i1.wr_ready, 1);
        write1(OP_LOAD, 2, 8'h5A);
        chk("ab_load0", i0.regs_flat[2*8 +: 8], 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
